stack_ram_burst: RTL and testbench
==================================

Name: stack_ram_burst

Overview:
Parametrised multi-word stack memory engine. It replaces the single-shot ram_read/ram_write stubs with a real storage array and a burst state machine. Moves 1..MAX_WORDS words per request, one word per clock, between the array and a packed wide bus, for LOAD/STORE (1 word) and SUPERMANDIVE/GETUP (full register file) style transfers. Uses the CPU's level start/done handshake.

Parameters:
DATA_W, 16, bits per word
ADDR_W, 16, word-address width
MAX_WORDS, 16, maximum words per burst; packed bus width is DATA_W*MAX_WORDS
DEPTH, 256, words of storage; addresses wrap modulo DEPTH

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; held high by requester until done seen
write  in  1  1 = write burst, 0 = read burst; sampled with start
address  in  ADDR_W  base word address
words  in  ADDR_W  burst length in words
wdata  in  DATA_W*MAX_WORDS  write data, word 0 in the MS slice
rdata  out  DATA_W*MAX_WORDS  read data, word 0 in the MS slice
done  out  1  burst complete; held while start high
busy  out  1  state != IDLE
error  out  1  illegal length; valid while done high

Behaviour:
- Reset (async, reset_n low): state=IDLE; done=0, busy=0, error=0, rdata=0; counters cleared. Array contents are neither reset nor altered. Reset mid-burst aborts it; words already written stay written.
- States: IDLE, BURST, DONE.
- IDLE, start=1 at edge: latch address, words, write, wdata.
  - words==0 or words>MAX_WORDS -> DONE with error=1, no array access.
  - Otherwise -> BURST, idx=0. A read burst clears rdata to 0 at this edge.
- BURST, one access per cycle at (address+idx) mod DEPTH:
  - write: store wdata slice idx (slice idx = bits [DATA_W*(MAX_WORDS-idx)-1 -: DATA_W]).
  - read: load the array word into rdata slice idx. The array read is combinational, so data is captured on the same edge.
  - At idx==words-1 -> DONE; else idx+1.
- DONE: done=1, error as decided. When start is sampled low -> IDLE, clearing done and error.
- Latency: done is visible words+1 cycles after the edge that samples start (2 cycles for 1 word). Error bursts: done after 1 cycle.
- start dropping during BURST does not abort; the burst completes, done is high for exactly 1 cycle, then IDLE.
- start still high in DONE: stay in DONE. A new request needs start low for at least 1 cycle.
- rdata slices at idx>=words read as 0. rdata holds its value after DONE until the next read burst starts. Write bursts leave rdata unchanged.
- Address arithmetic: (address+idx) truncated to ADDR_W, then mod DEPTH. DEPTH must be a power of two, so the mod is a bit slice. A burst crossing DEPTH-1 wraps to 0.
- Read-after-write in consecutive bursts sees the new data, since the write completes at the edge before DONE.

Decomposition:
- Shared package: state enum (IDLE, BURST, DONE), slice-index helper, default width constants shared with the CPU opcode constants.
- Sub-module stack_ram_array:
  - DEPTH x DATA_W storage.
  - One synchronous write port (clock, we, waddr, wdata).
  - One combinational read port.
  - No reset.
- Top level: FSM, counter, packing/unpacking.

Test Plan:
1. Write words=1, address=5, wdata MS slice=16'hBEEF; then read words=1, address=5 -> done after 2 cycles, rdata MS slice=16'hBEEF, other slices 0, error=0.
2. Write words=16, address=0, slice i=i+1; read back words=16 -> rdata equals wdata; done exactly 17 cycles after start sampled; busy high throughout.
3. Write words=4, address=254, slices 16'h0A..16'h0D; read words=2, address=0 -> slices 0,1 = 16'h0C,16'h0D (wrap confirmed); slices 2..15 = 0.
4. words=0, then words=17 -> done after 1 cycle with error=1; a following read of previously written addresses shows them unchanged.
5. Drop start 2 cycles into an 8-word write -> all 8 words written, done pulses 1 cycle, returns to IDLE.
6. Assert reset_n low mid-way through a 16-word write -> done/busy/error/rdata go 0 immediately without waiting for a clock edge; words written before reset read back correctly after reset.

Source files
------------

// File: rtl/stack_ram_burst_pkg.sv
// Shared definitions for the stack memory burst engine: default widths,
// the transfer sizes the CPU opcodes use, the FSM state type and the
// packed-bus slice helper.
package stack_ram_burst_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_MAX_WORDS = 16;
    localparam int DEF_DEPTH     = 256;

    // Transfer sizes used by the CPU: LOAD/STORE move one word,
    // SUPERMANDIVE/GETUP move the whole register file.
    localparam int LOADSTORE_WORDS = 1;
    localparam int REGFILE_WORDS   = DEF_MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // LSB position of word idx on the packed bus; word 0 sits in the MS slice.
    function automatic int unsigned slice_lsb(input int unsigned idx,
                                              input int unsigned data_w,
                                              input int unsigned max_words);
        return data_w * (max_words - 32'd1 - idx);
    endfunction

endpackage

// File: rtl/stack_ram_burst_if.sv
// Request/response bundle between the CPU (master) and the burst engine (slave).
interface stack_ram_burst_if
    import stack_ram_burst_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
);

    logic                          start;
    logic                          write;
    logic [ADDR_W-1:0]             address;
    logic [ADDR_W-1:0]             words;
    logic [DATA_W*MAX_WORDS-1:0]   wdata;
    logic [DATA_W*MAX_WORDS-1:0]   rdata;
    logic                          done;
    logic                          busy;
    logic                          error;

    modport master (
        output start, write, address, words, wdata,
        input  rdata, done, busy, error
    );

    modport slave (
        input  start, write, address, words, wdata,
        output rdata, done, busy, error
    );

endinterface

// File: rtl/stack_ram_burst_array.sv
// Word storage for the stack: one synchronous write port, one
// combinational read port, deliberately without reset so contents
// survive a CPU reset.
module stack_ram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_ram_burst.sv
// Multi-word stack memory engine: moves 1..MAX_WORDS words per request,
// one per clock, between the storage array and the packed wide bus,
// using the CPU's level start/done handshake.
module stack_ram_burst
    import stack_ram_burst_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic               clock,
    input  logic               reset_n,
    stack_ram_burst_if.slave   bus
);

    localparam int                DEPTH_AW    = $clog2(DEPTH);
    localparam int                BUS_W       = DATA_W * MAX_WORDS;
    localparam logic [ADDR_W-1:0] MAX_WORDS_W = ADDR_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ONE_W       = ADDR_W'(1);

    state_t              state_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [ADDR_W-1:0]   address_r;
    logic [ADDR_W-1:0]   words_r;
    logic                write_r;
    logic [BUS_W-1:0]    wdata_r;
    logic [BUS_W-1:0]    rdata_r;
    logic                done_r;
    logic                busy_r;
    logic                error_r;

    logic                len_bad_s;
    logic                mem_we_s;
    logic [DEPTH_AW-1:0] mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [DATA_W-1:0]   mem_rdata_s;
    int unsigned         lsb_s;

    // Current word's address (truncated to ADDR_W, then wrapped into DEPTH),
    // its slice on the packed bus, and the length check for a new request.
    always_comb begin
        lsb_s       = slice_lsb(32'(idx_r), DATA_W, MAX_WORDS);
        mem_addr_s  = DEPTH_AW'(address_r + idx_r);
        mem_we_s    = (state_r == BURST) && write_r;
        mem_wdata_s = wdata_r[lsb_s +: DATA_W];
        len_bad_s   = (bus.words == '0) || (bus.words > MAX_WORDS_W);
    end

    stack_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (DEPTH_AW)
    ) u_array (
        .clock  (clock),
        .we     (mem_we_s),
        .waddr  (mem_addr_s),
        .wdata  (mem_wdata_s),
        .raddr  (mem_addr_s),
        .rdata  (mem_rdata_s)
    );

    // Burst FSM: latches the request, walks idx across the burst and
    // holds done until the requester drops start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            address_r <= '0;
            words_r   <= '0;
            write_r   <= 1'b0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        address_r <= bus.address;
                        words_r   <= bus.words;
                        write_r   <= bus.write;
                        wdata_r   <= bus.wdata;
                        idx_r     <= '0;
                        busy_r    <= 1'b1;
                        if (len_bad_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                        end else begin
                            state_r <= BURST;
                            if (!bus.write) begin
                                rdata_r <= '0;
                            end
                        end
                    end
                end
                BURST: begin
                    if (!write_r) begin
                        rdata_r[lsb_s +: DATA_W] <= mem_rdata_s;
                    end
                    if (idx_r == (words_r - ONE_W)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r <= idx_r + ONE_W;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                        error_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.done  = done_r;
    assign bus.busy  = busy_r;
    assign bus.error = error_r;

endmodule

// File: tb/tb_stack_ram_burst.sv
// Directed self-checking bench for stack_ram_burst.
module tb_stack_ram_burst;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    stack_ram_burst_if bus ();

    stack_ram_burst dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue a request and count clock edges (starting with the sampling
    // edge) until done is seen; start stays high afterwards.
    task automatic do_burst(input logic wr, input logic [15:0] addr,
                            input logic [15:0] n, input logic [255:0] wd,
                            output int cyc, output logic busy_all);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.write   = wr;
        bus.address = addr;
        bus.words   = n;
        bus.wdata   = wd;
        cyc         = 0;
        busy_all    = 1'b1;
        while (cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.busy !== 1'b1) busy_all = 1'b0;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic end_burst();
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++;
        if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", bus.error); end
        total++;
        if (bus.rdata !== 256'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
    endtask

    task automatic test_single();
        int c; logic b; logic [255:0] wd; logic [255:0] exp;
        wd = '0; wd[255:240] = 16'hBEEF;
        do_burst(1'b1, 16'd5, 16'd1, wd, c, b);
        total++;
        if (c !== 2) begin bad++; $display("FAIL single_wr_lat got=%0d want=2", c); end
        end_burst();
        do_burst(1'b0, 16'd5, 16'd1, '0, c, b);
        total++;
        if (c !== 2) begin bad++; $display("FAIL single_rd_lat got=%0d want=2", c); end
        exp = '0; exp[255:240] = 16'hBEEF;
        total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL single_rdata got=%h want=%h", bus.rdata, exp); end
        total++;
        if (bus.error !== 1'b0) begin bad++; $display("FAIL single_error got=%b want=0", bus.error); end
        end_burst();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL single_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_full();
        int c; logic b; logic [255:0] wd;
        wd = '0;
        for (int i = 0; i < 16; i++) wd[16*(15-i) +: 16] = 16'(i + 1);
        do_burst(1'b1, 16'd0, 16'd16, wd, c, b);
        total++;
        if (c !== 17) begin bad++; $display("FAIL full_wr_lat got=%0d want=17", c); end
        total++;
        if (b !== 1'b1) begin bad++; $display("FAIL full_wr_busy got=%b want=1", b); end
        end_burst();
        do_burst(1'b0, 16'd0, 16'd16, '0, c, b);
        total++;
        if (c !== 17) begin bad++; $display("FAIL full_rd_lat got=%0d want=17", c); end
        total++;
        if (b !== 1'b1) begin bad++; $display("FAIL full_rd_busy got=%b want=1", b); end
        total++;
        if (bus.rdata !== wd) begin bad++; $display("FAIL full_rdata got=%h want=%h", bus.rdata, wd); end
        end_burst();
    endtask

    task automatic test_wrap();
        int c; logic b; logic [255:0] wd; logic [255:0] exp;
        wd = '0;
        wd[255:192] = {16'h000A, 16'h000B, 16'h000C, 16'h000D};
        do_burst(1'b1, 16'd254, 16'd4, wd, c, b);
        end_burst();
        do_burst(1'b0, 16'd0, 16'd2, '0, c, b);
        exp = '0; exp[255:224] = {16'h000C, 16'h000D};
        total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL wrap_low got=%h want=%h", bus.rdata, exp); end
        end_burst();
        do_burst(1'b0, 16'd254, 16'd2, '0, c, b);
        exp = '0; exp[255:224] = {16'h000A, 16'h000B};
        total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL wrap_high got=%h want=%h", bus.rdata, exp); end
        end_burst();
    endtask

    task automatic test_error();
        int c; logic b; logic [255:0] exp;
        do_burst(1'b1, 16'd254, 16'd0, {256{1'b1}}, c, b);
        total++;
        if (c !== 1) begin bad++; $display("FAIL err0_lat got=%0d want=1", c); end
        total++;
        if (bus.error !== 1'b1) begin bad++; $display("FAIL err0_flag got=%b want=1", bus.error); end
        end_burst();
        total++;
        if (bus.error !== 1'b0) begin bad++; $display("FAIL err0_clear got=%b want=0", bus.error); end
        do_burst(1'b1, 16'd254, 16'd17, {256{1'b1}}, c, b);
        total++;
        if (c !== 1) begin bad++; $display("FAIL err17_lat got=%0d want=1", c); end
        total++;
        if (bus.error !== 1'b1) begin bad++; $display("FAIL err17_flag got=%b want=1", bus.error); end
        end_burst();
        do_burst(1'b0, 16'd254, 16'd4, '0, c, b);
        exp = '0;
        exp[255:192] = {16'h000A, 16'h000B, 16'h000C, 16'h000D};
        total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL err_untouched got=%h want=%h", bus.rdata, exp); end
        total++;
        if (bus.error !== 1'b0) begin bad++; $display("FAIL err_after_read got=%b want=0", bus.error); end
        end_burst();
    endtask

    task automatic test_drop_start();
        int c; int done_cnt; logic b; logic [255:0] wd; logic [255:0] exp;
        wd = '0;
        for (int i = 0; i < 8; i++) wd[16*(15-i) +: 16] = 16'h0100 + 16'(i);
        @(negedge clock);
        bus.start = 1'b1; bus.write = 1'b1; bus.address = 16'd32;
        bus.words = 16'd8; bus.wdata = wd;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL drop_done_pulse got=%0d want=1", done_cnt); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_idle busy got=%b want=0", bus.busy); end
        do_burst(1'b0, 16'd32, 16'd8, '0, c, b);
        exp = wd;
        total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL drop_rdata got=%h want=%h", bus.rdata, exp); end
        end_burst();
    endtask

    task automatic test_reset_mid();
        int c; logic b; logic [255:0] wd; logic [255:0] exp;
        wd = '0;
        for (int i = 0; i < 16; i++) wd[16*(15-i) +: 16] = 16'h0200 + 16'(i);
        @(negedge clock);
        bus.start = 1'b1; bus.write = 1'b1; bus.address = 16'd64;
        bus.words = 16'd16; bus.wdata = wd;
        for (int k = 0; k < 5; k++) @(posedge clock);
        @(negedge clock);
        total++;
        if (bus.busy !== 1'b1 || bus.rdata === 256'h0) begin
            bad++; $display("FAIL rst_pre busy=%b rdata=%h want busy 1 rdata nonzero", bus.busy, bus.rdata);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
            bad++; $display("FAIL rst_async done=%b busy=%b error=%b want 0 0 0", bus.done, bus.busy, bus.error);
        end
        total++;
        if (bus.rdata !== 256'h0) begin bad++; $display("FAIL rst_async_rdata got=%h want=0", bus.rdata); end
        bus.start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_burst(1'b0, 16'd64, 16'd4, '0, c, b);
        exp = '0;
        exp[255:192] = {16'h0200, 16'h0201, 16'h0202, 16'h0203};
        total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL rst_kept got=%h want=%h", bus.rdata, exp); end
        end_burst();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.write   = 1'b0;
        bus.address = '0;
        bus.words   = '0;
        bus.wdata   = '0;
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_single();
        test_full();
        test_wrap();
        test_error();
        test_drop_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
